// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO. It performs one shift-add or
// restoring-subtract step per cycle and stalls the front-end until the result is written.
module muldiv_unit #(
   parameter int DATA_SIZE = 32,
   parameter int OP_SIZE   = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [OP_SIZE-1:0]   i_op,
   input  logic                 i_flush,
   input  logic [DATA_SIZE-1:0] i_A,
   input  logic [DATA_SIZE-1:0] i_B,
   output logic                 o_stall,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [DATA_SIZE-1:0] o_hi,
   output logic [DATA_SIZE-1:0] o_lo
);
   localparam int N  = DATA_SIZE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             div_q, div_d;
   logic             sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
   logic [N-1:0]     a_q, a_d, b_q, b_d;
   logic [2*N-1:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     hi_q, hi_d, lo_q, lo_d;

   logic             op_arith, op_signed;
   logic [N:0]       mul_sum;
   logic [N+1:0]     div_diff;
   logic [2*N-1:0]   prod_fix;
   logic [N-1:0]     quo, rem;

   assign op_arith  = (i_op <= OP_SIZE'(3));
   assign op_signed = ~i_op[0];

   // Multiply: the upper half accumulates, the product shifts right into the lower half.
   assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (b_q[0] ? {1'b0, a_q} : '0);
   // Divide: the upper half is the partial remainder, the lower half shifts dividend out and quotient in.
   assign div_diff = {1'b0, acc_q[2*N-1:N-1]} - {2'b00, b_q};
   assign prod_fix = (sgn_a_q ^ sgn_b_q) ? -acc_q : acc_q;
   assign quo      = acc_q[N-1:0];
   assign rem      = acc_q[2*N-1:N];

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      sgn_a_d = sgn_a_q;
      sgn_b_d = sgn_b_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (i_start && op_arith) begin
               state_d = S_PREP;
               div_d   = i_op[1];
               sgn_a_d = op_signed & i_A[N-1];
               sgn_b_d = op_signed & i_B[N-1];
               a_d     = sgn_a_d ? -i_A : i_A;
               b_d     = sgn_b_d ? -i_B : i_B;
            end
         end
         S_PREP: begin
            acc_d   = div_q ? {{N{1'b0}}, a_q} : '0;
            cnt_d   = CW'(N - 1);
            state_d = S_RUN;
         end
         S_RUN: begin
            if (div_q) begin
               acc_d = div_diff[N+1] ? {acc_q[2*N-2:0], 1'b0}
                                     : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
            end else begin
               acc_d = {mul_sum, acc_q[N-1:1]};
               b_d   = b_q >> 1;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               // A zero divisor leaves the dividend magnitude as remainder; re-signing it restores i_A.
               hi_d = sgn_a_q ? -rem : rem;
               lo_d = (b_q == '0) ? '1 : ((sgn_a_q ^ sgn_b_q) ? -quo : quo);
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if ((state_q == S_IDLE || state_q == S_DONE) && i_start) begin
         if (i_op == OP_SIZE'(4)) hi_d = i_A;
         if (i_op == OP_SIZE'(5)) lo_d = i_A;
      end
      if (i_flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         div_q   <= 1'b0;
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sgn_a_q <= sgn_a_d;
         sgn_b_q <= sgn_b_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign o_stall = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX) ||
                    ((state_q == S_IDLE) && i_start && op_arith);
   assign o_busy  = (state_q != S_IDLE);
   assign o_done  = (state_q == S_DONE);
   assign o_hi    = hi_q;
   assign o_lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against an
// arithmetic reference model, MTHI/MTLO, flush and asynchronous reset scenarios.
module tb_muldiv_unit;
   localparam int N = 32;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_flush = 1'b0;
   logic [2:0]    i_op = 3'd7;
   logic [N-1:0]  i_A = '0;
   logic [N-1:0]  i_B = '0;
   logic          o_stall, o_busy, o_done;
   logic [N-1:0]  o_hi, o_lo;

   int            checks = 0;
   int            errors = 0;
   logic [N-1:0]  m_hi = '0;
   logic [N-1:0]  m_lo = '0;

   muldiv_unit #(.DATA_SIZE(N), .OP_SIZE(3)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_op    (i_op),
      .i_flush (i_flush),
      .i_A     (i_A),
      .i_B     (i_B),
      .o_stall (o_stall),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_hi    (o_hi),
      .o_lo    (o_lo)
   );

   always #5 i_clk = ~i_clk;

   // Reference: {HI,LO} from plain 64-bit / 32-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int qa, qb;
      logic [31:0] q, r;
      case (op)
         3'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
         end
         3'd1: return {32'h0, a} * {32'h0, b};
         3'd2, 3'd3: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (op == 3'd2) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
               qa = $signed(a);
               qb = $signed(b);
               q  = qa / qb;
               r  = qa % qb;
            end else begin
               q = a / b;
               r = a % b;
            end
            return {r, q};
         end
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] s [5];
      s = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 4))
         0:       return 32'($urandom_range(0, 40)) - 32'd20;
         1:       return s[$urandom_range(0, 4)];
         default: return $urandom();
      endcase
   endfunction

   // Issues one op in cycle 0 and observes cycles 0..37; i_flush is pulsed in cycle flush_at.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int done_cycle, output int done_count,
                        output int stall_count, output logic busy1);
      done_cycle = -1;
      done_count = 0;
      stall_count = 0;
      busy1 = 1'b0;
      @(negedge i_clk);
      i_start = 1'b1; i_op = op; i_A = a; i_B = b; i_flush = (flush_at == 0);
      #1;
      if (o_stall) stall_count++;
      for (int k = 1; k <= 37; k++) begin
         @(negedge i_clk);
         i_start = 1'b0; i_op = 3'd7; i_flush = (flush_at == k);
         #1;
         if (o_stall) stall_count++;
         if (o_done) begin
            done_count++;
            if (done_cycle < 0) done_cycle = k;
         end
         if (k == 1) busy1 = o_busy;
      end
      i_flush = 1'b0;
      $display("op=%0d a=%h b=%h flush_at=%0d -> hi=%h lo=%h done_cycle=%0d stalls=%0d",
               op, a, b, flush_at, o_hi, o_lo, done_cycle, stall_count);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) @(negedge i_clk);
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
      checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
      checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [2:0]  t_op  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2};
      logic [31:0] t_a   [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000, 32'hFFFF_FFFB};
      logic [31:0] t_b   [7] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] t_hi  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h64, 32'h0, 32'hFFFF_FFFB};
      logic [31:0] t_lo  [7] = '{32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      int dc, dn, sc;
      logic b1;
      for (int i = 0; i < 7; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], -1, dc, dn, sc, b1);
         checks++; if (o_hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, o_hi, t_hi[i]); end
         checks++; if (o_lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, o_lo, t_lo[i]); end
         checks++; if (dc != 35) begin errors++; $display("FAIL dir%0d_done_cycle got=%0d exp=35", i, dc); end
         checks++; if (dn != 1) begin errors++; $display("FAIL dir%0d_done_pulses got=%0d exp=1", i, dn); end
         checks++; if (sc != 35) begin errors++; $display("FAIL dir%0d_stall_cycles got=%0d exp=35", i, sc); end
         checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b exp=1", i, b1); end
         m_hi = t_hi[i];
         m_lo = t_lo[i];
      end
   endtask

   task automatic test_mthi_mtlo();
      @(negedge i_clk);
      i_start = 1'b1; i_op = 3'd4; i_A = 32'h1234;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got=%b exp=0", o_stall); end
      @(negedge i_clk);
      i_op = 3'd5; i_A = 32'h5678;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall got=%b exp=0", o_stall); end
      checks++; if (o_hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got=%h exp=00001234", o_hi); end
      @(negedge i_clk);
      i_op = 3'd6; i_A = 32'hDEAD_BEEF;
      #1;
      checks++; if (o_lo !== 32'h5678) begin errors++; $display("FAIL mtlo_lo got=%h exp=00005678", o_lo); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mt_busy got=%b exp=0", o_busy); end
      @(negedge i_clk);
      i_start = 1'b0; i_op = 3'd7;
      #1;
      checks++; if (o_hi !== 32'h1234) begin errors++; $display("FAIL nop_hi got=%h exp=00001234", o_hi); end
      checks++; if (o_lo !== 32'h5678) begin errors++; $display("FAIL nop_lo got=%h exp=00005678", o_lo); end
      $display("mthi=00001234 mtlo=00005678 nop -> hi=%h lo=%h", o_hi, o_lo);
      m_hi = 32'h1234;
      m_lo = 32'h5678;
   endtask

   task automatic test_flush();
      int fa [3] = '{10, 34, 0};
      int dc, dn, sc;
      logic b1;
      for (int i = 0; i < 3; i++) begin
         do_op(3'($urandom_range(0, 3)), pick(), pick(), fa[i], dc, dn, sc, b1);
         checks++; if (dn != 0) begin errors++; $display("FAIL flush%0d_done got=%0d exp=0", fa[i], dn); end
         checks++; if (o_hi !== m_hi) begin errors++; $display("FAIL flush%0d_hi got=%h exp=%h", fa[i], o_hi, m_hi); end
         checks++; if (o_lo !== m_lo) begin errors++; $display("FAIL flush%0d_lo got=%h exp=%h", fa[i], o_lo, m_lo); end
         checks++; if (sc != fa[i] + 1) begin errors++; $display("FAIL flush%0d_stall_cycles got=%0d exp=%0d", fa[i], sc, fa[i] + 1); end
         checks++; if (b1 !== (fa[i] != 0)) begin errors++; $display("FAIL flush%0d_busy got=%b exp=%b", fa[i], b1, fa[i] != 0); end
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush%0d_idle got=%b exp=0", fa[i], o_busy); end
      end
   endtask

   task automatic test_mt_in_done();
      for (int v = 0; v < 2; v++) begin
         @(negedge i_clk);
         i_start = 1'b1; i_op = 3'd1; i_A = 32'd3; i_B = 32'd4;
         @(negedge i_clk);
         i_start = 1'b0; i_op = 3'd7;
         repeat (34) @(negedge i_clk);
         #1;
         checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done%0d_pulse got=%b exp=1", v, o_done); end
         i_start = 1'b1; i_op = (v == 0) ? 3'd5 : 3'd0; i_A = 32'hA5A5_0001; i_B = 32'd1;
         #1;
         checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL done%0d_stall got=%b exp=0", v, o_stall); end
         @(negedge i_clk);
         i_start = 1'b0; i_op = 3'd7;
         #1;
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL done%0d_nostart got=%b exp=0", v, o_busy); end
         checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL done%0d_hi got=%h exp=0", v, o_hi); end
         checks++; if (o_lo !== ((v == 0) ? 32'hA5A5_0001 : 32'd12)) begin
            errors++; $display("FAIL done%0d_lo got=%h exp=%h", v, o_lo, (v == 0) ? 32'hA5A5_0001 : 32'd12);
         end
         $display("multu 3*4 then op=%0d in DONE -> hi=%h lo=%h busy=%b", (v == 0) ? 5 : 0, o_hi, o_lo, o_busy);
      end
      m_hi = 32'h0;
      m_lo = 32'd12;
   endtask

   task automatic test_async_reset();
      @(negedge i_clk);
      i_start = 1'b1; i_op = 3'd4; i_A = 32'hCAFE;
      @(negedge i_clk);
      i_op = 3'd0; i_A = 32'hFFFF_FFFD; i_B = 32'd5;
      @(negedge i_clk);
      i_start = 1'b0; i_op = 3'd7;
      repeat (19) @(negedge i_clk);
      #1;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before got=%b exp=1", o_busy); end
      checks++; if (o_hi !== 32'hCAFE) begin errors++; $display("FAIL arst_hi_before got=%h exp=0000cafe", o_hi); end
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", o_stall); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", o_done); end
      checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL arst_hi got=%h exp=0", o_hi); end
      checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL arst_lo got=%h exp=0", o_lo); end
      $display("async reset in cycle 20 -> hi=%h lo=%h busy=%b", o_hi, o_lo, o_busy);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      m_hi = 32'h0;
      m_lo = 32'h0;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      int dc, dn, sc;
      logic b1;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 3));
         a = pick();
         b = pick();
         exp = model(op, a, b);
         do_op(op, a, b, -1, dc, dn, sc, b1);
         checks++; if (o_hi !== exp[63:32]) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, o_hi, exp[63:32]); end
         checks++; if (o_lo !== exp[31:0]) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, o_lo, exp[31:0]); end
         checks++; if (dc != 35) begin errors++; $display("FAIL rnd%0d_done_cycle got=%0d exp=35", i, dc); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_flush();
      test_mt_in_done();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
